// File: rtl/xilinx_reset_sequencer.sv
// Orders the release of NUM_DOMAINS resets once PLL/MMCM lock is stable.
// Each domain is released only after the previous one acknowledges ready and
// a stagger gap elapses. Lock loss, soft_reset or a ready timeout re-asserts all.
// Ports:
//   clk, rst_n      sequencer clock, async active-low reset
//   pll_locked      lock status (synchronised to clk)
//   soft_reset      synchronous restart request
//   domain_ready    per-domain out-of-reset acknowledge
//   domain_reset    per-domain active-high reset
//   busy            1 while not in ST_RUN
//   all_released    1 only in ST_RUN
//   cur_domain      domain currently being released or awaited
//   timeout_err     1-cycle pulse on ready timeout
//   state_o         FSM state encoding
module xilinx_reset_sequencer #(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned LOCK_FILTER    = 4,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned READY_TIMEOUT  = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   soft_reset,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   busy,
  output logic                   all_released,
  output logic [3:0]             cur_domain,
  output logic                   timeout_err,
  output logic [2:0]             state_o
);

  localparam int unsigned LOCK_W = $clog2(LOCK_FILTER + 1);
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_WAIT_RDY  = 3'd3,
    ST_STAGGER   = 3'd4,
    ST_RUN       = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [LOCK_W-1:0]      lock_cnt, lock_cnt_nxt;
  logic [IDX_W-1:0]       cur_nxt;
  logic [NUM_DOMAINS-1:0] domain_reset_nxt;
  logic                   busy_nxt;
  logic                   all_released_nxt;
  logic                   timeout_nxt;
  logic                   lock_ok;
  logic                   ready_sel;
  logic                   abort;

  assign state_o = state;
  assign lock_ok = (lock_cnt == LOCK_W'(LOCK_FILTER));
  // Lock loss is ignored in ST_ASSERT, where everything is already held.
  assign abort   = (!pll_locked && (state != ST_ASSERT)) || soft_reset;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ASSERT;
      cnt          <= CNT_W'(HOLD_CYCLES - 1);
      lock_cnt     <= '0;
      cur_domain   <= '0;
      domain_reset <= '1;
      busy         <= 1'b1;
      all_released <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      lock_cnt     <= lock_cnt_nxt;
      cur_domain   <= cur_nxt;
      domain_reset <= domain_reset_nxt;
      busy         <= busy_nxt;
      all_released <= all_released_nxt;
      timeout_err  <= timeout_nxt;
    end
  end

  // Ready bit of the domain being awaited
  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
      if (cur_domain == IDX_W'(i)) ready_sel = domain_ready[i];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    cur_nxt          = cur_domain;
    domain_reset_nxt = domain_reset;
    timeout_nxt      = 1'b0;
    lock_cnt_nxt     = lock_cnt;

    // Saturating lock filter
    if (!pll_locked)   lock_cnt_nxt = '0;
    else if (!lock_ok) lock_cnt_nxt = lock_cnt + LOCK_W'(1);

    case (state)
      ST_ASSERT: begin
        domain_reset_nxt = '1;
        if (cnt == '0) state_nxt = ST_WAIT_LOCK;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_WAIT_LOCK: begin
        if (lock_ok) begin
          state_nxt = ST_RELEASE;
          cur_nxt   = '0;
        end
      end
      ST_RELEASE: begin
        for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
          if (cur_domain == IDX_W'(i)) domain_reset_nxt[i] = 1'b0;
        end
        state_nxt = ST_WAIT_RDY;
        cnt_nxt   = CNT_W'(READY_TIMEOUT - 1);
      end
      ST_WAIT_RDY: begin
        if (ready_sel) begin
          if (cur_domain == IDX_W'(NUM_DOMAINS - 1)) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_STAGGER;
            cnt_nxt   = CNT_W'(STAGGER_CYCLES - 1);
          end
        end else if (cnt == '0) begin
          timeout_nxt      = 1'b1;
          state_nxt        = ST_ASSERT;
          domain_reset_nxt = '1;
          cur_nxt          = '0;
          cnt_nxt          = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_STAGGER: begin
        if (cnt == '0) begin
          state_nxt = ST_RELEASE;
          cur_nxt   = cur_domain + IDX_W'(1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_RUN: begin
        domain_reset_nxt = '0;
      end
      default: begin
        state_nxt        = ST_ASSERT;
        domain_reset_nxt = '1;
        cur_nxt          = '0;
        cnt_nxt          = CNT_W'(HOLD_CYCLES - 1);
      end
    endcase

    // Abort wins over any same-cycle ready or timeout
    if (abort) begin
      state_nxt        = ST_ASSERT;
      domain_reset_nxt = '1;
      cur_nxt          = '0;
      cnt_nxt          = CNT_W'(HOLD_CYCLES - 1);
      timeout_nxt      = 1'b0;
    end

    busy_nxt         = (state_nxt != ST_RUN);
    all_released_nxt = (state_nxt == ST_RUN);
  end

endmodule

// File: tb/tb_xilinx_reset_sequencer.sv
// Directed bench for xilinx_reset_sequencer: ordered release, lock loss,
// ready timeout, soft reset, async reset and lock filtering.
module tb_xilinx_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_reset;
  logic [3:0] domain_ready;
  logic [3:0] domain_reset;
  logic       busy;
  logic       all_released;
  logic [3:0] cur_domain;
  logic       timeout_err;
  logic [2:0] state_o;

  int         n_checks;
  int         n_errors;
  int         cyc;
  int         age [4];
  logic [3:0] block;

  xilinx_reset_sequencer #(
    .NUM_DOMAINS(4), .HOLD_CYCLES(16), .LOCK_FILTER(4),
    .STAGGER_CYCLES(8), .READY_TIMEOUT(32), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_reset(soft_reset),
    .domain_ready(domain_ready), .domain_reset(domain_reset), .busy(busy),
    .all_released(all_released), .cur_domain(cur_domain),
    .timeout_err(timeout_err), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One edge, then a ready model: ready rises so the DUT samples it on the
  // third edge after the domain's release; blocked domains never respond.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (domain_reset[i]) begin
        age[i] = 0;
        domain_ready[i] = 1'b0;
      end else begin
        age[i]++;
        if (age[i] >= 3 && !block[i]) domain_ready[i] = 1'b1;
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; block = 4'h0;
    for (int i = 0; i < 4; i++) age[i] = 0;
    rst_n = 1'b0; pll_locked = 1'b1; soft_reset = 1'b0; domain_ready = 4'h0;

    tick(); tick();
    check("rst_dr", 32'(domain_reset), 32'hF);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_allrel", 32'(all_released), 32'd0);
    check("rst_cur", 32'(cur_domain), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);

    // T1: ordered release, lock stable from reset
    cyc = 0;
    rst_n = 1'b1;
    run_to(15); check("t1_hold_state", 32'(state_o), 32'd0);
                check("t1_hold_dr", 32'(domain_reset), 32'hF);
    run_to(16); check("t1_waitlock", 32'(state_o), 32'd1);
    run_to(17); check("t1_release", 32'(state_o), 32'd2);
                check("t1_release_dr", 32'(domain_reset), 32'hF);
    run_to(18); check("t1_d0_dr", 32'(domain_reset), 32'hE);
                check("t1_d0_state", 32'(state_o), 32'd3);
    run_to(21); check("t1_stagger", 32'(state_o), 32'd4);
    run_to(29); check("t1_rel1_cur", 32'(cur_domain), 32'd1);
                check("t1_rel1_dr", 32'(domain_reset), 32'hE);
    run_to(30); check("t1_d1_dr", 32'(domain_reset), 32'hC);
    run_to(41); check("t1_pre_d2", 32'(domain_reset), 32'hC);
    run_to(42); check("t1_d2_dr", 32'(domain_reset), 32'h8);
    run_to(54); check("t1_d3_dr", 32'(domain_reset), 32'h0);
                check("t1_d3_cur", 32'(cur_domain), 32'd3);
    run_to(56); check("t1_busy_pre", 32'(busy), 32'd1);
    run_to(57); check("t1_run", 32'(state_o), 32'd5);
                check("t1_allrel", 32'(all_released), 32'd1);
                check("t1_busy", 32'(busy), 32'd0);

    // T4: soft reset pulse in ST_RUN
    run_to(60);
    soft_reset = 1'b1;
    run_to(61); soft_reset = 1'b0;
                check("t4_allrel", 32'(all_released), 32'd0);
                check("t4_dr", 32'(domain_reset), 32'hF);
                check("t4_state", 32'(state_o), 32'd0);
    run_to(76); check("t4_hold", 32'(domain_reset), 32'hF);
    run_to(77); check("t4_waitlock", 32'(state_o), 32'd1);
    run_to(78); check("t4_still_held", 32'(domain_reset), 32'hF);
    run_to(79); check("t4_d0_dr", 32'(domain_reset), 32'hE);
    run_to(91); check("t4_d1_dr", 32'(domain_reset), 32'hC);

    // T2: 2-cycle lock loss in ST_STAGGER after domain 1
    run_to(95); check("t2_stagger", 32'(state_o), 32'd4);
                check("t2_cur", 32'(cur_domain), 32'd1);
    pll_locked = 1'b0;
    run_to(96); check("t2_abort_dr", 32'(domain_reset), 32'hF);
                check("t2_abort_state", 32'(state_o), 32'd0);
                check("t2_abort_cur", 32'(cur_domain), 32'd0);
    run_to(97); pll_locked = 1'b1;
    run_to(111); check("t2_hold", 32'(state_o), 32'd0);
    run_to(112); check("t2_waitlock", 32'(state_o), 32'd1);
    run_to(114); check("t2_d0_dr", 32'(domain_reset), 32'hE);

    // T3: domain 2 never ready -> timeout and retry
    block = 4'b0100;
    run_to(138); check("t3_d2_dr", 32'(domain_reset), 32'h8);
    run_to(169); check("t3_pre_tmo", 32'(timeout_err), 32'd0);
                 check("t3_pre_state", 32'(state_o), 32'd3);
    run_to(170); check("t3_tmo", 32'(timeout_err), 32'd1);
                 check("t3_tmo_dr", 32'(domain_reset), 32'hF);
                 check("t3_tmo_state", 32'(state_o), 32'd0);
    run_to(171); check("t3_tmo_pulse", 32'(timeout_err), 32'd0);
    run_to(186); check("t3_retry_wl", 32'(state_o), 32'd1);
    run_to(188); check("t3_retry_d0", 32'(domain_reset), 32'hE);

    // T5: async reset in ST_WAIT_RDY, no clock edge
    run_to(200); check("t5_pre_state", 32'(state_o), 32'd3);
                 check("t5_pre_dr", 32'(domain_reset), 32'hC);
                 check("t5_pre_cur", 32'(cur_domain), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_dr", 32'(domain_reset), 32'hF);
    check("t5_state", 32'(state_o), 32'd0);
    check("t5_cur", 32'(cur_domain), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);

    // T6: lock glitch 1-0-1, filter must see 4 consecutive highs
    tick();
    block = 4'h0;
    cyc = 0;
    pll_locked = 1'b0;
    rst_n = 1'b1;
    run_to(11); pll_locked = 1'b1;
    run_to(14); pll_locked = 1'b0;
    run_to(15); pll_locked = 1'b1;
                check("t6_hold", 32'(state_o), 32'd0);
    run_to(16); check("t6_wl", 32'(state_o), 32'd1);
    run_to(19); check("t6_wl_filter", 32'(state_o), 32'd1);
    run_to(20); check("t6_release", 32'(state_o), 32'd2);
    run_to(21); check("t6_d0_dr", 32'(domain_reset), 32'hE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
